fp_cop_sequencer: RTL and testbench
===================================

FP_COP_SEQUENCER -- requirements
Module: fp_cop_sequencer

Interface
REQ-001 Parameter: ALU_LAT, default 2, cycles spent in EXEC waiting on the FP ALU (legal 1..15).
REQ-002 Parameter: N, default 32, data width; ADDR_W, default 5, register address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  FP instruction offered by integer pipeline.
REQ-006 req_ready  out  1  sequencer can accept an instruction.
REQ-007 req_op  in  3  000 ADD, 001 SUB, 010 MOV, 011 MTC1, 100 MFC1, others illegal.
REQ-008 req_fd/req_fs/req_ft  in  ADDR_W each  destination, source 1, source 2 FP register.
REQ-009 req_wdata  in  N  integer data for MTC1.
REQ-010 rf_rs_addr/rf_rt_addr/rf_rd_addr  out  ADDR_W each  FP register-file addresses.
REQ-011 rf_write  out  1  FP register-file write enable; rf_write_data  out  N.
REQ-012 rf_read_data_1/rf_read_data_2  in  N  combinational register-file read data.
REQ-013 alu_operand_1/alu_operand_2  out  N; alu_operation  out  1 (0 add, 1 sub); alu_result  in  N.
REQ-014 resp_valid  out  1; resp_data  out  N; resp_ready  in  1  MFC1 return handshake.
REQ-015 busy  out  1; illegal_op  out  1 one-cycle pulse; done_count  out  16.

Function
REQ-016 FSM states IDLE, READ, EXEC, WB, RESP; single-issue, blocking; req_ready = 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready at a rising edge; op, fd, fs, ft, wdata latched at that edge.
REQ-018 IDLE on accept: illegal op -> stay IDLE, illegal_op high next cycle only; MTC1 -> WB with result = wdata; others -> READ.
REQ-019 rf_rs_addr = latched fs, rf_rt_addr = latched ft, rf_rd_addr = latched fd, always driven from latches.
REQ-020 READ (one cycle): operand registers capture rf_read_data_1/2 at end of cycle; ADD/SUB -> EXEC, MOV -> WB (result = read_data_1), MFC1 -> RESP.
REQ-021 EXEC: alu_operand_1/2 = operand registers, alu_operation = op[0]; 4-bit counter loaded ALU_LAT-1 on entry, decrements; at count 0 result register captures alu_result, -> WB; EXEC lasts exactly ALU_LAT cycles.
REQ-022 WB (one cycle): rf_write = 1, rf_write_data = result; rf_write = 0 in every other state; -> IDLE.
REQ-023 RESP: resp_valid = 1, resp_data = operand 1; held stable until resp_ready sampled high, then -> IDLE; resp_valid = 0 elsewhere.
REQ-024 Latency from accept edge (cycle 0): ADD/SUB write in cycle 2+ALU_LAT; MOV write in cycle 2; MTC1 write in cycle 1; MFC1 resp_valid from cycle 2.
REQ-025 done_count increments by 1 on each WB cycle and each RESP completion; wraps 0xFFFF -> 0x0000; illegal ops not counted.
REQ-026 busy = (state != IDLE).
REQ-027 req_valid while not IDLE is ignored; no queueing; offered instruction must be held by requester.
REQ-028 No special case for register 0; FP register 0 is writable.

Reset
REQ-029 reset asserted: state -> IDLE immediately, all latches, operands, result, counter, done_count -> 0.
REQ-030 During/after reset: rf_write = 0, resp_valid = 0, illegal_op = 0, busy = 0, req_ready = 1 once reset deasserts.
REQ-031 Reset mid-operation (READ/EXEC/WB/RESP) aborts with no register-file write issued after assertion and no count increment.

Verification
REQ-032 f1=0x40000000, f2=0x3F800000, ADD fd=3 fs=1 ft=2, ALU_LAT=2 -> rf_write only in cycle 4, rd=3, data 0x40400000, done_count=1.
REQ-033 Same operands, SUB fd=4 -> alu_operation=1 during EXEC, write 0x3F800000 to f4 in cycle 4.
REQ-034 MTC1 fd=5 wdata=0x12345678 -> write in cycle 1, rd=5, data 0x12345678; then MFC1 fs=5 with resp_ready low 3 cycles -> resp_valid held 4 cycles, resp_data 0x12345678, req_ready low until completion.
REQ-035 req_op=111 -> illegal_op pulse one cycle, no rf_write, done_count unchanged, req_ready stays 1.
REQ-036 reset asserted during EXEC of ADD -> no rf_write, busy=0, done_count=0; next ADD completes normally.
REQ-037 0xFFFF completions preloaded via long run, one more -> done_count=0x0000.

Source files
------------

// File: rtl/fp_cop_sequencer.sv
// Single-issue FP coprocessor sequencer: accepts one FP instruction at a time, steps
// through register-file read, a fixed-latency external ALU, write-back or an MFC1 return.
module fp_cop_sequencer #(
    parameter int ALU_LAT = 2,
    parameter int N       = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_fd,
    input  logic [ADDR_W-1:0] req_fs,
    input  logic [ADDR_W-1:0] req_ft,
    input  logic [N-1:0]      req_wdata,

    output logic [ADDR_W-1:0] rf_rs_addr,
    output logic [ADDR_W-1:0] rf_rt_addr,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic              rf_write,
    output logic [N-1:0]      rf_write_data,
    input  logic [N-1:0]      rf_read_data_1,
    input  logic [N-1:0]      rf_read_data_2,

    output logic [N-1:0]      alu_operand_1,
    output logic [N-1:0]      alu_operand_2,
    output logic              alu_operation,
    input  logic [N-1:0]      alu_result,

    output logic              resp_valid,
    output logic [N-1:0]      resp_data,
    input  logic              resp_ready,

    output logic              busy,
    output logic              illegal_op,
    output logic [15:0]       done_count,
    output logic [2:0]        dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // an MFC1 result transfers on a rising edge where resp_valid && resp_ready, and
    // resp_valid/resp_data stay stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_MTC1 = 3'b011;
    localparam logic [2:0] OP_MFC1 = 3'b100;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] fd_q, fs_q, ft_q;
    logic [N-1:0]      op1_q, op2_q, result_q;
    logic [3:0]        cnt_q;
    logic [15:0]       done_q;
    logic              req_ready_q, busy_q, rf_write_q, resp_valid_q, illegal_q;

    logic accept;
    logic op_legal;

    assign accept   = req_valid & req_ready_q;
    assign op_legal = (req_op <= OP_MFC1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && op_legal) begin
                    state_d = (req_op == OP_MTC1) ? S_WB : S_READ;
                end
            end
            S_READ: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    state_d = S_EXEC;
                end else if (op_q == OP_MOV) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WB;
                end
            end
            S_WB:   state_d = S_IDLE;
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            fd_q         <= '0;
            fs_q         <= '0;
            ft_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            done_q       <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rf_write_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
            rf_write_q   <= (state_d == S_WB);
            resp_valid_q <= (state_d == S_RESP);
            illegal_q    <= accept && !op_legal;

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        fd_q <= req_fd;
                        fs_q <= req_fs;
                        ft_q <= req_ft;
                        if (req_op == OP_MTC1) begin
                            result_q <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    op1_q <= rf_read_data_1;
                    op2_q <= rf_read_data_2;
                    cnt_q <= LAT_M1;
                    if (op_q == OP_MOV) begin
                        result_q <= rf_read_data_1;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_q <= alu_result;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WB: done_q <= done_q + 16'd1;
                S_RESP: begin
                    if (resp_ready) begin
                        done_q <= done_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign illegal_op    = illegal_q;
    assign done_count    = done_q;
    assign dbg_state     = state_q;

    assign rf_rs_addr    = fs_q;
    assign rf_rt_addr    = ft_q;
    assign rf_rd_addr    = fd_q;
    assign rf_write      = rf_write_q;
    assign rf_write_data = result_q;

    assign alu_operand_1 = op1_q;
    assign alu_operand_2 = op2_q;
    assign alu_operation = op_q[0];

    assign resp_valid    = resp_valid_q;
    assign resp_data     = op1_q;

endmodule

// File: tb/tb_fp_cop_sequencer.sv
// Bench for fp_cop_sequencer: behavioural FP register file and ALU around the DUT,
// directed and random instructions checked against a per-instruction timing model.
module tb_fp_cop_sequencer;

    localparam int ALU_LAT = 2;
    localparam int N       = 32;
    localparam int AW      = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_MTC1 = 3'b011;
    localparam logic [2:0] OP_MFC1 = 3'b100;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_fd, req_fs, req_ft;
    logic [N-1:0]  req_wdata;
    logic [AW-1:0] rf_rs_addr, rf_rt_addr, rf_rd_addr;
    logic          rf_write;
    logic [N-1:0]  rf_write_data, rf_read_data_1, rf_read_data_2;
    logic [N-1:0]  alu_operand_1, alu_operand_2, alu_result;
    logic          alu_operation;
    logic          resp_valid, resp_ready;
    logic [N-1:0]  resp_data;
    logic          busy, illegal_op;
    logic [15:0]   done_count;
    logic [2:0]    dbg_state;

    int            errors = 0;
    int            checks = 0;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  m_rf[32];
    logic [15:0]   exp_done;
    logic [2:0]    idle_code;

    fp_cop_sequencer #(.ALU_LAT(ALU_LAT), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_fd(req_fd), .req_fs(req_fs), .req_ft(req_ft), .req_wdata(req_wdata),
        .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rd_addr(rf_rd_addr),
        .rf_write(rf_write), .rf_write_data(rf_write_data),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_operation(alu_operation), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .busy(busy), .illegal_op(illegal_op), .done_count(done_count),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // single precision <-> double, exact for normal values and zero
    function automatic real s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] d2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        return d2s(sub ? s2d(a) - s2d(b) : s2d(a) + s2d(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        int v;
        v = int'($urandom_range(0, 2000)) - 1000;
        return d2s(real'(v));
    endfunction

    // behavioural register file and FP ALU surrounding the DUT
    logic [N-1:0] rf[32];
    always_ff @(posedge clk) if (rf_write) rf[rf_rd_addr] <= rf_write_data;
    assign rf_read_data_1 = rf[rf_rs_addr];
    assign rf_read_data_2 = rf[rf_rt_addr];
    always_comb alu_result = fp_ref(alu_operand_1, alu_operand_2, alu_operation);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Driver + scoreboard for one instruction, entered and left at a falling edge.
    task automatic run_op(input logic [2:0] op, input logic [4:0] fd, input logic [4:0] fs,
                          input logic [4:0] ft, input logic [31:0] wd, input int stall);
        int wc, rc, end_c, last;
        bit illegal;
        logic [31:0] ev;
        wc = -1; rc = -1; ev = '0;
        illegal = (op > OP_MFC1);
        case (op)
            OP_ADD, OP_SUB: begin wc = 2 + ALU_LAT; ev = fp_ref(m_rf[fs], m_rf[ft], op[0]); end
            OP_MOV:  begin wc = 2; ev = m_rf[fs]; end
            OP_MTC1: begin wc = 1; ev = wd; end
            OP_MFC1: begin rc = 2; ev = m_rf[fs]; end
            default: ;
        endcase
        if (!illegal) exp_q.push_back(ev);
        end_c = (wc > 0) ? wc : (rc > 0) ? rc + stall : 0;
        last  = illegal ? 2 : end_c + 1;

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_fd = fd; req_fs = fs; req_ft = ft; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            chk("rf_write", rf_write, (c == wc));
            chk("resp_valid", resp_valid, (rc > 0 && c >= rc && c <= rc + stall));
            chk("busy", busy, (c <= end_c));
            chk("req_ready", req_ready, (c > end_c));
            chk("state_idle", (dbg_state === idle_code), (c > end_c));
            chk("illegal_op", illegal_op, (illegal && c == 1));
            if (wc > 0 && c >= 2 && c < wc && op != OP_MOV && op != OP_MTC1)
                chk("alu_operation", alu_operation, op[0]);
            if (c == wc) begin
                chk("rf_rd_addr", rf_rd_addr, fd);
                chk("rf_write_data", rf_write_data, exp_q.pop_front());
                m_rf[fd] = ev;
            end
            if (rc > 0 && c >= rc && c <= rc + stall) begin
                chk("resp_data", resp_data, exp_q[0]);
                if (c == rc + stall) void'(exp_q.pop_front());
            end
            resp_ready = (rc > 0 && c >= rc + stall && c <= end_c);
            if (c == last) begin
                if (!illegal) exp_done = exp_done + 16'd1;
                chk("done_count", done_count, exp_done);
            end else begin
                @(negedge clk);
            end
        end
        resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_fd = '0; req_fs = '0; req_ft = '0;
        req_wdata = '0; resp_ready = 1'b0; exp_done = '0;
        repeat (3) @(negedge clk);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
        idle_code = dbg_state;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        // fill every FP register with random integer-valued floats
        for (int i = 0; i < 32; i++) run_op(OP_MTC1, 5'(i), 5'd0, 5'd0, rnd_fp(), 0);

        // 2.0 + 1.0, then 2.0 - 1.0
        run_op(OP_MTC1, 5'd1, 5'd0, 5'd0, 32'h4000_0000, 0);
        run_op(OP_MTC1, 5'd2, 5'd0, 5'd0, 32'h3F80_0000, 0);
        run_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        chk("add_result_f3", m_rf[3], 32'h4040_0000);
        run_op(OP_SUB, 5'd4, 5'd1, 5'd2, 32'd0, 0);
        run_op(OP_MOV, 5'd6, 5'd3, 5'd0, 32'd0, 0);

        // MTC1 then MFC1 with a three-cycle stalled return
        run_op(OP_MTC1, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 0);
        run_op(OP_MFC1, 5'd0, 5'd5, 5'd0, 32'd0, 3);

        run_op(3'b111, 5'd7, 5'd1, 5'd2, 32'd0, 0);

        // reset during EXEC of an ADD aborts it
        req_valid = 1'b1; req_op = OP_ADD; req_fd = 5'd3; req_fs = 5'd1; req_ft = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_exec", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rf_write", rf_write, 0);
        chk("abort_done", done_count, 0);
        chk("abort_resp_valid", resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_done = '0;
        repeat (4) begin
            @(negedge clk);
            chk("post_abort_rf_write", rf_write, 0);
            chk("post_abort_busy", busy, 0);
        end
        run_op(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        chk("readd_result_f3", m_rf[3], 32'h4040_0000);

        // random instruction stream
        for (int i = 0; i < 200; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), rnd_fp(), int'($urandom_range(0, 3)));
        end

        // completion counter wrap, preloaded just short of the top
        force dut.done_q = 16'hFFFE;
        #1;
        release dut.done_q;
        exp_done = 16'hFFFE;
        run_op(OP_MTC1, 5'd9, 5'd0, 5'd0, rnd_fp(), 0);
        run_op(OP_MFC1, 5'd0, 5'd9, 5'd0, 32'd0, 1);
        chk("wrap_done", done_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
